// File: rtl/key_filter_pkg.sv
// Shared definitions for the key filter array: one-hot channel states and a
// counter width helper.
package key_filter_pkg;

  // One-hot channel states; any other pattern is treated as corruption.
  typedef enum logic [3:0] {
    IDLE           = 4'b0001,
    FILTER_DOWN    = 4'b0010,
    DOWN           = 4'b0100,
    FILTER_RELEASE = 4'b1000
  } chan_state_e;

  // Bits needed to count 0..max_val-1 (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/key_chan_fsm.sv
// One key channel: input synchroniser, edge sampling, debounce FSM and the
// debounce / hold / repeat counters that produce the press, long and repeat
// pulses.
module key_chan_fsm
  import key_filter_pkg::*;
#(
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000,
  parameter int REP_MAX  = 10_000_000,
  parameter int REP_EN   = 1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic key_long,
  output logic key_rep
);

  localparam int DEB_W  = cnt_width(CNT_MAX);
  localparam int HOLD_W = cnt_width(LONG_MAX + 1);
  localparam int REP_W  = cnt_width(REP_MAX);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(CNT_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(LONG_MAX);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_MAX - 1);

  logic sync_a, sync_b, samp_r1, samp_r2;
  logic fall, rise;

  chan_state_e       state;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;

  logic              long_hit;
  logic              hold_done;
  logic [HOLD_W-1:0] hold_step;
  logic              rep_run;
  logic              rep_wrap;
  logic [REP_W-1:0]  rep_step;

  // Synchronise the raw level, sample it twice and register the edge strobes
  // so the FSM sees a clean one-cycle event per level change.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_a  <= 1'b1;
      sync_b  <= 1'b1;
      samp_r1 <= 1'b1;
      samp_r2 <= 1'b1;
      fall    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_a  <= key_in;
      sync_b  <= sync_a;
      samp_r1 <= sync_b;
      samp_r2 <= samp_r1;
      fall    <= !samp_r1 & samp_r2;
      rise    <= samp_r1 & !samp_r2;
    end
  end

  // Next values for the saturating hold counter and the wrapping repeat counter.
  always_comb begin
    long_hit  = (hold_cnt == HOLD_LAST);
    hold_done = (hold_cnt == HOLD_DONE);
    hold_step = hold_done ? hold_cnt : hold_cnt + 1'b1;
    rep_run   = (REP_EN != 0) && hold_done;
    rep_wrap  = (rep_cnt == REP_LAST);
    rep_step  = rep_wrap ? '0 : rep_cnt + 1'b1;
  end

  // Debounce FSM with registered pulse and level outputs; an edge always
  // beats a debounce expiry landing in the same cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
      key_long  <= 1'b0;
      key_rep   <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      key_long <= 1'b0;
      key_rep  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= FILTER_DOWN;
            deb_cnt <= '0;
          end
        end
        FILTER_DOWN: begin
          if (rise) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= DOWN;
            key_flag  <= 1'b1;
            key_state <= 1'b0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        DOWN: begin
          hold_cnt <= hold_step;
          key_long <= long_hit;
          if (rise) begin
            state   <= FILTER_RELEASE;
            deb_cnt <= '0;
          end else if (rep_run) begin
            rep_cnt <= rep_step;
            key_rep <= rep_wrap;
          end
        end
        FILTER_RELEASE: begin
          if (fall) begin
            state    <= DOWN;
            hold_cnt <= hold_step;
            key_long <= long_hit;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= IDLE;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
          end else begin
            deb_cnt  <= deb_cnt + 1'b1;
            hold_cnt <= hold_step;
            key_long <= long_hit;
          end
        end
        default: begin
          state     <= IDLE;
          deb_cnt   <= '0;
          hold_cnt  <= '0;
          rep_cnt   <= '0;
          key_state <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_array_filter.sv
// Array of independent key debounce channels, one per key_in bit.
module key_array_filter #(
  parameter int KEY_NUM  = 4,
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000,
  parameter int REP_MAX  = 10_000_000,
  parameter int REP_EN   = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_rep
);

  genvar gi;
  generate
    for (gi = 0; gi < KEY_NUM; gi++) begin : g_chan
      key_chan_fsm #(
        .CNT_MAX (CNT_MAX),
        .LONG_MAX(LONG_MAX),
        .REP_MAX (REP_MAX),
        .REP_EN  (REP_EN)
      ) u_chan (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .key_in   (key_in[gi]),
        .key_flag (key_flag[gi]),
        .key_state(key_state[gi]),
        .key_long (key_long[gi]),
        .key_rep  (key_rep[gi])
      );
    end
  endgenerate

endmodule
